program_loader_memory: RTL and testbench
========================================

Name: program_loader_memory

Overview:
- Instruction memory for the NanoRisc core, with a built-in boot loader; sits directly upstream of the core.
- After reset it accepts a length-prefixed byte stream over a valid/ready port and writes it into instruction RAM from address 0. It then pads the remaining locations.
- While loading it holds the core in reset. Once the load completes it serves instruction fetches combinationally from the core's PC.

Parameters:
- ADDR_W, 8, instruction address width; depth = 2**ADDR_W.
- DATA_W, 8, instruction/byte width.
- PAD, 8'h00, value written to unloaded locations; also the value driven on instruction while not in RUN.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- loadStart  input  1  single-cycle pulse; restarts loading from HEADER.
- loadValid  input  1  loader byte valid.
- loadData  input  DATA_W  loader byte.
- loadReady  output  1  block accepts loadData this cycle.
- instructionAddress  input  ADDR_W  fetch address, driven by the core PC.
- instruction  output  DATA_W  fetched instruction, fed to the core.
- cpuReset  output  1  holds the core in reset; high except in RUN.
- loadDone  output  1  high in RUN.
- loadError  output  1  checksum failure flag; see Optional Feature.

Behaviour:
- Clock and reset: one clock, `clock`. Reset is `reset`, synchronous and active-high.
- On reset: state = HEADER, cpuReset=1, loadReady=1, loadDone=0, loadError=0, write pointer=0, remaining count=0. RAM contents are not cleared.
- Transfer rule: a byte transfers on a rising edge where loadValid && loadReady. loadReady is combinational from state only: 1 in HEADER, DATA and CHECK; 0 elsewhere. loadReady never depends on loadValid.
- HEADER:
  - Transferred byte is the length N.
  - N=0 means 2**ADDR_W bytes.
  - Set pointer=0, then go to DATA.
- DATA:
  - Each transfer writes mem[pointer] <= loadData, increments pointer, decrements remaining.
  - After the Nth byte: go to CHECK if CHECKSUM_EN is defined, otherwise to FILL.
  - If N = 2**ADDR_W, go to RUN instead of FILL (pointer wraps to 0; no pad writes).
- FILL:
  - One pad write per cycle: mem[pointer] <= PAD, pointer++.
  - After writing the last address (2**ADDR_W-1), go to RUN.
  - Fill latency = 2**ADDR_W - N cycles.
- RUN:
  - cpuReset=0 and loadDone=1, registered: both change on the edge that enters RUN.
  - instruction = mem[instructionAddress], asynchronous read, zero-cycle latency.
  - No writes occur.
- Outside RUN, instruction = PAD regardless of address.
- loadStart (any state):
  - Next state HEADER; cpuReset=1 and loadDone=0 on the same edge; pointer cleared; loadError cleared.
  - A transfer that coincides with loadStart is discarded; loadStart wins.
- Reset mid-load behaves like loadStart: RAM keeps whatever was written so far.
- Pointer arithmetic is modulo 2**ADDR_W; the remaining-count register is ADDR_W+1 bits wide.
- State encoding: HEADER, DATA, CHECK, FILL, RUN, ERROR.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Defined:
  - One extra byte follows the data, accepted in CHECK.
  - Required: (sum of the data bytes + checksum byte) mod 256 == 0.
  - Pass: go to FILL (or RUN if N = 2**ADDR_W).
  - Fail: go to ERROR, with loadError=1, cpuReset=1, loadReady=0.
  - ERROR is left only via loadStart or reset.
  - The running sum is an 8-bit register cleared in HEADER.
- Undefined: CHECK and ERROR are unreachable and not built; loadError is tied to 0.

Decomposition:
- Package program_loader_pkg: state enum (HEADER, DATA, CHECK, FILL, RUN, ERROR); default constants for ADDR_W, DATA_W, PAD.
- Sub-module instruction_ram: parameterized depth x DATA_W, one synchronous write port (we, waddr, wdata) and one asynchronous read port. The loader FSM, pointer and checksum stay in the top module.

Test Plan:
- Basic load: reset, then stream 03, A1, B2, C3 with loadValid held high -> mem[0..2] = A1, B2, C3, mem[3..255] = 00. loadDone rises 253 cycles after the last byte. Fetch addr 1 -> instruction = B2, same cycle.
- Full-depth load: length 00 followed by 256 bytes (value = index) -> no FILL cycles; RUN is entered on the edge after byte 255; fetch addr 255 -> FF.
- Backpressure and gaps: random loadValid gaps of 0-5 cycles during a 5-byte load -> identical RAM image to the gap-free case; loadReady stays 1 throughout HEADER and DATA.
- Restart: loadStart pulsed after 2 of 4 bytes, coincident with a valid byte -> that byte is dropped; cpuReset stays 1; state returns to HEADER; a fresh 02, 11, 22 load gives mem[0..1] = 11, 22.
- Run behaviour: in RUN, drive loadValid=1 -> loadReady=0 and no RAM change. Sweep instructionAddress 0..5 -> outputs match the loaded image; cpuReset=0.
- Checksum (PROGRAM_LOADER_CHECKSUM_EN defined): 02, 10, 20, D0 -> RUN. 02, 10, 20, D1 -> ERROR with loadError=1 and cpuReset=1, held until loadStart.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared types and defaults for the NanoRisc program loader / instruction memory.
package program_loader_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;
    localparam logic [7:0]  PAD_DEF    = 8'h00;

    // Loader state encoding; CHECK and ERROR are only reachable with the checksum build.
    typedef enum logic [2:0] {
        ST_HEADER = 3'd0,
        ST_DATA   = 3'd1,
        ST_CHECK  = 3'd2,
        ST_FILL   = 3'd3,
        ST_RUN    = 3'd4,
        ST_ERROR  = 3'd5
    } state_e;

    // The loader port is ready purely as a function of state, never of loadValid.
    function automatic logic ready_for_state(input state_e st);
        logic rdy;
        case (st)
            ST_HEADER: rdy = 1'b1;
            ST_DATA:   rdy = 1'b1;
            ST_CHECK:  rdy = 1'b1;
            default:   rdy = 1'b0;
        endcase
        return rdy;
    endfunction

endpackage

// File: rtl/program_loader_instruction_ram.sv
// Instruction RAM: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module instruction_ram
    import program_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port: one location per clock when we is asserted.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/program_loader_memory.sv
// Instruction memory with built-in boot loader for the NanoRisc core.
// Accepts a length-prefixed byte stream, writes it from address 0, pads the
// rest with PAD, then releases the core and serves fetches combinationally.
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN (trailing checksum byte).
module program_loader_memory
    import program_loader_pkg::*;
#(
    parameter int unsigned       ADDR_W = ADDR_W_DEF,
    parameter int unsigned       DATA_W = DATA_W_DEF,
    parameter logic [DATA_W-1:0] PAD    = DATA_W'(PAD_DEF)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              loadStart,
    input  logic              loadValid,
    input  logic [DATA_W-1:0] loadData,
    output logic              loadReady,
    input  logic [ADDR_W-1:0] instructionAddress,
    output logic [DATA_W-1:0] instruction,
    output logic              cpuReset,
    output logic              loadDone,
    output logic              loadError
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned REM_W = ADDR_W + 1;
    localparam logic [REM_W-1:0] FULL_CNT = REM_W'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              load_done_q, load_done_d;
    logic              xfer_s;
    logic              we_s;
    logic [DATA_W-1:0] wdata_s;
    logic [DATA_W-1:0] rdata_s;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [DATA_W-1:0] sum_next_s;
    logic              load_error_q, load_error_d;

    assign sum_next_s = sum_q + loadData;
`endif

    assign loadReady = ready_for_state(state_q);
    assign xfer_s    = loadValid && loadReady;

    // Loader FSM: next state, pointer, remaining count and RAM write control.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        cpu_reset_d = cpu_reset_q;
        load_done_d = load_done_q;
        we_s        = 1'b0;
        wdata_s     = loadData;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum_d        = sum_q;
        load_error_d = load_error_q;
`endif
        if (loadStart) begin
            // Restart wins over any coincident transfer.
            state_d     = ST_HEADER;
            ptr_d       = {ADDR_W{1'b0}};
            rem_d       = {REM_W{1'b0}};
            cpu_reset_d = 1'b1;
            load_done_d = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            load_error_d = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_HEADER: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_d = {DATA_W{1'b0}};
`endif
                    if (xfer_s) begin
                        // A length of zero encodes a full-depth image.
                        ptr_d   = {ADDR_W{1'b0}};
                        rem_d   = (loadData == {DATA_W{1'b0}}) ? FULL_CNT : REM_W'(loadData);
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_HEADER;
                    end
                end
                ST_DATA: begin
                    if (xfer_s) begin
                        we_s  = 1'b1;
                        ptr_d = ptr_q + ADDR_W'(1);
                        rem_d = rem_q - REM_W'(1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        sum_d = sum_next_s;
`endif
                        if (rem_q == REM_W'(1)) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                            state_d = ST_CHECK;
`else
                            // Pointer wrapped to 0 only for a full-depth image: no padding needed.
                            if (ptr_d == {ADDR_W{1'b0}}) begin
                                state_d     = ST_RUN;
                                cpu_reset_d = 1'b0;
                                load_done_d = 1'b1;
                            end else begin
                                state_d = ST_FILL;
                            end
`endif
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (xfer_s) begin
                        if (sum_next_s == {DATA_W{1'b0}}) begin
                            // Pointer is 0 here only when the whole memory was loaded.
                            if (ptr_q == {ADDR_W{1'b0}}) begin
                                state_d     = ST_RUN;
                                cpu_reset_d = 1'b0;
                                load_done_d = 1'b1;
                            end else begin
                                state_d = ST_FILL;
                            end
                        end else begin
                            state_d      = ST_ERROR;
                            load_error_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
                ST_ERROR: begin
                    state_d = ST_ERROR;
                end
`endif
                ST_FILL: begin
                    we_s    = 1'b1;
                    wdata_s = PAD;
                    ptr_d   = ptr_q + ADDR_W'(1);
                    if (ptr_q == {ADDR_W{1'b1}}) begin
                        state_d     = ST_RUN;
                        cpu_reset_d = 1'b0;
                        load_done_d = 1'b1;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d     = ST_HEADER;
                    ptr_d       = {ADDR_W{1'b0}};
                    rem_d       = {REM_W{1'b0}};
                    cpu_reset_d = 1'b1;
                    load_done_d = 1'b0;
                end
            endcase
        end
    end

    // State and control registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_HEADER;
            ptr_q       <= {ADDR_W{1'b0}};
            rem_q       <= {REM_W{1'b0}};
            cpu_reset_q <= 1'b1;
            load_done_q <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q        <= {DATA_W{1'b0}};
            load_error_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            cpu_reset_q <= cpu_reset_d;
            load_done_q <= load_done_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
            load_error_q <= load_error_d;
`endif
        end
    end

    instruction_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clock (clock),
        .we    (we_s),
        .waddr (ptr_q),
        .wdata (wdata_s),
        .raddr (instructionAddress),
        .rdata (rdata_s)
    );

    // Fetches see PAD until the image is complete.
    assign instruction = (state_q == ST_RUN) ? rdata_s : PAD;
    assign cpuReset    = cpu_reset_q;
    assign loadDone    = load_done_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    assign loadError   = load_error_q;
`else
    assign loadError   = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader_memory.sv
// Scoreboard bench for program_loader_memory: stimulus pushes expected
// values, a negedge monitor pops and compares against the DUT outputs.
module tb_program_loader_memory;

    localparam int K_INSTR  = 0;
    localparam int K_CPURST = 1;
    localparam int K_DONE   = 2;
    localparam int K_READY  = 3;
    localparam int K_ERR    = 4;

    typedef struct {
        int         kind;
        int         addr;
        logic [7:0] exp;
    } chk_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       loadStart = 1'b0;
    logic       loadValid = 1'b0;
    logic [7:0] loadData = 8'h00;
    logic       loadReady;
    logic [7:0] instructionAddress = 8'h00;
    logic [7:0] instruction;
    logic       cpuReset;
    logic       loadDone;
    logic       loadError;

    chk_t       sb_q[$];
    chk_t       mon_c;
    logic [7:0] mon_act;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] sum_m = 8'h00;

    program_loader_memory dut (
        .clock              (clock),
        .reset              (reset),
        .loadStart          (loadStart),
        .loadValid          (loadValid),
        .loadData           (loadData),
        .loadReady          (loadReady),
        .instructionAddress (instructionAddress),
        .instruction        (instruction),
        .cpuReset           (cpuReset),
        .loadDone           (loadDone),
        .loadError          (loadError)
    );

    always #5 clock = ~clock;

    function automatic string kname(input int k);
        case (k)
            K_INSTR:  return "instruction";
            K_CPURST: return "cpuReset";
            K_DONE:   return "loadDone";
            K_READY:  return "loadReady";
            K_ERR:    return "loadError";
            default:  return "unknown";
        endcase
    endfunction

    // Monitor: compare every queued expectation against the DUT away from the rising edge.
    always @(negedge clock) begin
        while (sb_q.size() > 0) begin
            mon_c = sb_q.pop_front();
            case (mon_c.kind)
                K_INSTR:  mon_act = instruction;
                K_CPURST: mon_act = {7'd0, cpuReset};
                K_DONE:   mon_act = {7'd0, loadDone};
                K_READY:  mon_act = {7'd0, loadReady};
                K_ERR:    mon_act = {7'd0, loadError};
                default:  mon_act = 8'hxx;
            endcase
            checks++;
            if (mon_act !== mon_c.exp) begin
                errors++;
                $display("FAIL %s addr=%0d got=%h expected=%h t=%0t",
                         kname(mon_c.kind), mon_c.addr, mon_act, mon_c.exp, $time);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic push_chk(input int kind, input logic [7:0] exp);
        chk_t c;
        c.kind = kind;
        c.addr = int'(instructionAddress);
        c.exp  = exp;
        sb_q.push_back(c);
    endtask

    task automatic sync();
        @(negedge clock);
        #1;
    endtask

    task automatic check_instr(input logic [7:0] addr, input logic [7:0] exp);
        instructionAddress = addr;
        push_chk(K_INSTR, exp);
        sync();
    endtask

    task automatic check_status(input logic cpurst, input logic done, input logic rdy);
        push_chk(K_CPURST, {7'd0, cpurst});
        push_chk(K_DONE,   {7'd0, done});
        push_chk(K_READY,  {7'd0, rdy});
        sync();
    endtask

    task automatic send(input logic [7:0] b);
        loadData  = b;
        loadValid = 1'b1;
        @(posedge clock);
        #1;
        sum_m = sum_m + b;
    endtask

    task automatic send_header(input logic [7:0] n);
        send(n);
        sum_m = 8'h00;
    endtask

    task automatic send_cksum();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        logic [7:0] ck;
        ck = 8'h00 - sum_m;
        send(ck);
`else
        loadValid = loadValid;
`endif
    endtask

    task automatic pulse_start();
        loadStart = 1'b1;
        @(posedge clock);
        #1;
        loadStart = 1'b0;
    endtask

    task automatic wait_run();
        for (int i = 0; i < 600; i++) begin
            if (loadDone) break;
            @(posedge clock);
            #1;
        end
        push_chk(K_DONE, 8'h01);
        sync();
    endtask

    localparam int GAPS [5] = '{3, 0, 5, 1, 2};

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        push_chk(K_ERR, 8'h00);
        check_status(1'b1, 1'b0, 1'b1);
        check_instr(8'h00, 8'h00);

        // Basic load: 03 A1 B2 C3, valid held high
        send_header(8'h03);
        send(8'hA1);
        send(8'hB2);
        send(8'hC3);
        send_cksum();
        loadValid = 1'b0;
        repeat (252) @(posedge clock);
        #1;
        push_chk(K_DONE, 8'h00);
        push_chk(K_CPURST, 8'h01);
        sync();
        @(posedge clock);
        #1;
        push_chk(K_DONE, 8'h01);
        push_chk(K_CPURST, 8'h00);
        sync();
        check_instr(8'h01, 8'hB2);
        check_instr(8'h00, 8'hA1);
        check_instr(8'h02, 8'hC3);
        check_instr(8'h03, 8'h00);
        check_instr(8'hFF, 8'h00);

        instructionAddress = 8'h01;
        #1;
        checks++;
        if (instruction !== 8'hB2) begin
            errors++;
            $display("FAIL direct fetch addr=1 got=%h expected=b2 t=%0t", instruction, $time);
        end

        // Run behaviour: loader port closed, no writes
        for (int i = 0; i < 3; i++) begin
            loadValid = 1'b1;
            loadData  = 8'hEE;
            push_chk(K_READY, 8'h00);
            sync();
            @(posedge clock);
            #1;
        end
        checks++;
        if (loadReady !== 1'b0) begin
            errors++;
            $display("FAIL direct loadReady in RUN got=%b expected=0 t=%0t", loadReady, $time);
        end
        loadValid = 1'b0;
        check_instr(8'h00, 8'hA1);
        check_instr(8'h01, 8'hB2);
        check_instr(8'h02, 8'hC3);
        check_instr(8'h03, 8'h00);
        check_instr(8'h04, 8'h00);
        check_instr(8'h05, 8'h00);
        check_status(1'b0, 1'b1, 1'b0);

        // Gapped 5-byte load
        pulse_start();
        check_status(1'b1, 1'b0, 1'b1);
        check_instr(8'h00, 8'h00);
        send_header(8'h05);
        for (int b = 0; b < 5; b++) begin
            loadValid = 1'b0;
            for (int g = 0; g < GAPS[b]; g++) begin
                push_chk(K_READY, 8'h01);
                sync();
                @(posedge clock);
                #1;
            end
            send(8'(b + 1));
        end
        send_cksum();
        loadValid = 1'b0;
        wait_run();
        for (int a = 0; a < 6; a++) begin
            check_instr(8'(a), (a < 5) ? 8'(a + 1) : 8'h00);
        end

        // Restart mid-load with a coincident valid byte
        pulse_start();
        send_header(8'h04);
        send(8'h55);
        send(8'h66);
        loadData  = 8'h77;
        loadValid = 1'b1;
        loadStart = 1'b1;
        @(posedge clock);
        #1;
        loadStart = 1'b0;
        loadValid = 1'b0;
        check_status(1'b1, 1'b0, 1'b1);
        send_header(8'h02);
        send(8'h11);
        send(8'h22);
        send_cksum();
        loadValid = 1'b0;
        wait_run();
        check_instr(8'h00, 8'h11);
        check_instr(8'h01, 8'h22);
        check_instr(8'h02, 8'h00);
        check_instr(8'h03, 8'h00);

        // Full-depth load: no fill cycles
        pulse_start();
        send_header(8'h00);
        for (int i = 0; i < 256; i++) begin
            send(8'(i));
        end
        send_cksum();
        loadValid = 1'b0;
        push_chk(K_DONE, 8'h01);
        push_chk(K_CPURST, 8'h00);
        sync();
        checks++;
        if (loadDone !== 1'b1) begin
            errors++;
            $display("FAIL direct loadDone after full load got=%b expected=1 t=%0t", loadDone, $time);
        end
        checks++;
        if (cpuReset !== 1'b0) begin
            errors++;
            $display("FAIL direct cpuReset after full load got=%b expected=0 t=%0t", cpuReset, $time);
        end
        check_instr(8'hFF, 8'hFF);
        check_instr(8'h00, 8'h00);
        check_instr(8'h80, 8'h80);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Checksum pass: 02 10 20 D0
        pulse_start();
        send(8'h02);
        send(8'h10);
        send(8'h20);
        send(8'hD0);
        loadValid = 1'b0;
        wait_run();
        check_instr(8'h00, 8'h10);
        check_instr(8'h01, 8'h20);
        check_instr(8'h02, 8'h00);

        // Checksum fail: 02 10 20 D1 -> ERROR until loadStart
        pulse_start();
        send(8'h02);
        send(8'h10);
        send(8'h20);
        send(8'hD1);
        loadValid = 1'b1;
        loadData  = 8'h00;
        for (int i = 0; i < 4; i++) begin
            push_chk(K_ERR, 8'h01);
            check_status(1'b1, 1'b0, 1'b0);
            @(posedge clock);
            #1;
        end
        loadValid = 1'b0;
        pulse_start();
        push_chk(K_ERR, 8'h00);
        check_status(1'b1, 1'b0, 1'b1);
`endif

        sync();
        if (errors != 0) begin
            $display("FAIL: %0d checks, %0d errors", checks, errors);
        end else begin
            $display("PASS: %0d checks, %0d errors", checks, errors);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
